lab06_1_driver: RTL
===================

// Module: lab06_1_driver
// PURPOSE
//  Synthesizable initiator for the lab06_1 datapath interface (in_valid/in_number/mode -> out_valid/out_result).
//  Serializes one host-supplied frame of 4-bit numbers plus a 2-bit mode onto the DUT input bus.
//  Waits for the DUT's single-cycle result, captures it and measures latency.
//  Compares the result with a host-supplied expected value and reports pass/fail plus protocol errors.
//  Used as the on-chip/bench stimulus and check engine wrapped around lab06_1.
// PARAMETERS
//  FRAME_LEN  6    numbers per frame (>=1)
//  TIMEOUT    64   max WAIT cycles before timeout error (>=1)
//  LAT_W      7    latency counter width; must hold TIMEOUT
// PORTS
//  clk             in   1            single clock, all logic on rising edge
//  rst             in   1            synchronous, active-high reset
//  start           in   1            begin frame; sampled only in IDLE
//  frame_data      in   4*FRAME_LEN  nibble k = bits[4k+3:4k]; nibble 0 sent first
//  frame_mode      in   2            mode for the frame
//  exp_result      in   7 signed     expected out_result
//  busy            out  1            high in SEND/WAIT/CHECK
//  done            out  1            one-cycle pulse at end of every frame
//  pass            out  1            valid with done, held until next start
//  err_code        out  2            0 NONE, 1 EARLY, 2 TIMEOUT, 3 LONG_VALID; held until next start
//  latency         out  LAT_W        WAIT cycles up to and incl. out_valid cycle
//  cap_result      out  7 signed     captured out_result
//  dut_in_valid    out  1            to DUT in_valid
//  dut_in_number   out  4            to DUT in_number
//  dut_mode        out  2            to DUT mode
//  dut_out_valid   in   1            from DUT out_valid
//  dut_out_result  in   7 signed     from DUT out_result
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (busy, done, pass, err_code, latency, cap_result, dut_*). Applies mid-frame:
//   dut_in_valid drops on the reset edge; no done pulse for the aborted frame.
//  All outputs registered. dut_in_number/dut_mode are 0 whenever dut_in_valid is 0.
//  IDLE: start=1 -> latch frame_data/frame_mode/exp_result, clear pass/err_code/latency/cap_result, go SEND.
//   start while busy is ignored (no relatch, no restart).
//  SEND: FRAME_LEN consecutive cycles of dut_in_valid=1; cycle k drives nibble k. dut_mode=frame_mode on
//   every SEND cycle. First SEND cycle is the cycle after start was sampled. After nibble FRAME_LEN-1 -> WAIT.
//  dut_out_valid=1 during SEND -> err EARLY, dut_in_valid deasserted next cycle, go CHECK (remaining nibbles dropped).
//  WAIT: counter starts at 1 on first WAIT cycle and increments each cycle.
//   dut_out_valid=1 -> cap_result<=dut_out_result, latency<=counter, go CHECK.
//   counter==TIMEOUT and no out_valid -> err TIMEOUT, latency<=TIMEOUT, go CHECK.
//   out_valid on the same cycle the counter hits TIMEOUT counts as a valid capture (not timeout).
//  CHECK (exactly 1 cycle): done=1; dut_out_valid still 1 -> err LONG_VALID (only if err_code was NONE).
//   pass = (err_code==NONE) && (cap_result==exp_result), bitwise 7-bit compare. Go IDLE.
//  Fixed frame timing: start sampled at cycle t -> in_valid cycles t+1..t+FRAME_LEN; done at out_valid cycle + 1.
//  Back-to-back: start may be high in the cycle after CHECK; minimum gap between frames is 1 IDLE cycle.
// STRUCTURE
//  Package lab06_pkg: state enum {IDLE,SEND,WAIT,CHECK}; err enum {ERR_NONE,ERR_EARLY,ERR_TIMEOUT,ERR_LONG};
//   widths NUM_W=4, MODE_W=2, RES_W=7.
//  One sub-module: lab06_frame_shifter (parallel-load nibble shift register + index counter, emits last_nibble).
//  Top holds FSM, WAIT counter, capture/compare registers.
// TESTING
//  1 Reset then start, frame_data=24'h654321, mode=2'b01, DUT model replies 3 cycles after last nibble with 7'sd21,
//    exp=21 -> in_number 1,2,3,4,5,6 on 6 cycles; latency=3, pass=1, err=0, done one cycle.
//  2 Same frame, DUT replies -7 (7'h79), exp=-7 -> pass=1; exp=+7 -> pass=0, err=0, cap_result=7'h79.
//  3 DUT never asserts out_valid -> done exactly TIMEOUT(64) cycles after WAIT entry, err=2, pass=0, latency=64.
//  4 DUT asserts out_valid during nibble 3 -> err=1, in_valid low from next cycle, done following, pass=0.
//  5 DUT holds out_valid 2 cycles -> err=3, pass=0; repeat with start re-pulsed during busy -> ignored.
//  6 rst asserted during SEND nibble 2 -> all outputs 0 next cycle, no done; fresh start afterwards passes.

Source files
------------

// File: rtl/lab06_pkg.sv
// Shared widths, FSM state and error-code encodings for the lab06_1 driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab06_pkg;

  localparam int NUM_W  = 4;   // one number on the DUT input bus
  localparam int MODE_W = 2;   // frame mode
  localparam int RES_W  = 7;   // signed DUT result

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_EARLY   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_LONG    = 2'd3
  } err_t;

endpackage

// File: rtl/lab06_frame_shifter.sv
// Holds the not-yet-sent nibbles of a frame and tracks which nibble is on the bus.
// Latency: next_nibble is valid the cycle after load; advances one nibble per shift.
// Backpressure: none; the owner decides when to shift.
// Ports: load/load_data capture a frame, shift advances, next_nibble is the nibble
//        to put on the bus next cycle, last_nibble flags that the bus holds the final one.
module lab06_frame_shifter
  import lab06_pkg::*;
#(
  parameter int FRAME_LEN = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       shift,
  input  logic [NUM_W*FRAME_LEN-1:0] load_data,
  output logic [NUM_W-1:0]           next_nibble,
  output logic                       last_nibble
);

  localparam int DATA_W = NUM_W * FRAME_LEN;
  localparam int IDX_W  = $clog2(FRAME_LEN + 1);

  // Nibble 0 goes straight onto the bus at load time, so only nibbles 1.. are
  // kept here; the low nibble is always the one to drive next.
  logic [DATA_W-1:0] sr;
  // Index of the nibble currently on the DUT bus.
  logic [IDX_W-1:0]  idx;

  assign next_nibble = sr[NUM_W-1:0];
  assign last_nibble = (idx == IDX_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= load_data >> NUM_W;
      idx <= '0;
    end else if (shift) begin
      sr  <= sr >> NUM_W;
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/lab06_1_driver.sv
// Sends one frame of nibbles + mode to lab06_1, captures its result, times it and checks it.
// Latency: nibbles on cycles t+1..t+FRAME_LEN after start at t; done one cycle after out_valid.
// Backpressure: none; start is ignored while busy, the DUT must answer within TIMEOUT cycles.
// Ports: start/frame_data/frame_mode/exp_result from the host; busy/done/pass/err_code/
//        latency/cap_result report back; dut_* connect to the lab06_1 datapath.
module lab06_1_driver
  import lab06_pkg::*;
#(
  parameter int FRAME_LEN = 6,
  parameter int TIMEOUT   = 64,
  parameter int LAT_W     = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_W*FRAME_LEN-1:0] frame_data,
  input  logic [MODE_W-1:0]          frame_mode,
  input  logic signed [RES_W-1:0]    exp_result,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 err_code,
  output logic [LAT_W-1:0]           latency,
  output logic signed [RES_W-1:0]    cap_result,
  output logic                       dut_in_valid,
  output logic [NUM_W-1:0]           dut_in_number,
  output logic [MODE_W-1:0]          dut_mode,
  input  logic                       dut_out_valid,
  input  logic signed [RES_W-1:0]    dut_out_result
);

  state_t                   state, state_n;
  err_t                     err_q, err_n;
  logic                     busy_n, done_n, pass_n;
  logic [LAT_W-1:0]         lat_n, wait_cnt, cnt_n;
  logic signed [RES_W-1:0]  cap_n, exp_r, exp_n;
  logic [MODE_W-1:0]        fmode_r, fmode_n, mode_n;
  logic                     vld_n;
  logic [NUM_W-1:0]         num_n;
  logic                     sh_load, sh_shift;
  logic [NUM_W-1:0]         next_nibble;
  logic                     last_nibble;

  assign err_code = err_q;

  lab06_frame_shifter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (sh_load),
    .shift       (sh_shift),
    .load_data   (frame_data),
    .next_nibble (next_nibble),
    .last_nibble (last_nibble)
  );

  // Every output is a register; this block computes their next values. The bus
  // defaults to idle so dut_in_number/dut_mode read 0 whenever in_valid is low.
  always_comb begin
    state_n  = state;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    err_n    = err_q;
    lat_n    = latency;
    cap_n    = cap_result;
    cnt_n    = wait_cnt;
    exp_n    = exp_r;
    fmode_n  = fmode_r;
    vld_n    = 1'b0;
    num_n    = '0;
    mode_n   = '0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = ERR_NONE;
          lat_n   = '0;
          cap_n   = '0;
          exp_n   = exp_result;
          fmode_n = frame_mode;
          sh_load = 1'b1;
          vld_n   = 1'b1;
          num_n   = frame_data[NUM_W-1:0];
          mode_n  = frame_mode;
        end
      end

      SEND: begin
        // A result before the frame is complete aborts the rest of the frame.
        if (dut_out_valid) begin
          err_n   = ERR_EARLY;
          pass_n  = 1'b0;
          done_n  = 1'b1;
          state_n = CHECK;
        end else if (last_nibble) begin
          cnt_n   = LAT_W'(1);
          state_n = WAIT;
        end else begin
          sh_shift = 1'b1;
          vld_n    = 1'b1;
          num_n    = next_nibble;
          mode_n   = fmode_r;
        end
      end

      WAIT: begin
        // A capture on the TIMEOUT-th cycle still wins over the timeout.
        if (dut_out_valid) begin
          cap_n   = dut_out_result;
          lat_n   = wait_cnt;
          pass_n  = (dut_out_result == exp_r);
          done_n  = 1'b1;
          state_n = CHECK;
        end else if (wait_cnt == LAT_W'(TIMEOUT)) begin
          err_n   = ERR_TIMEOUT;
          lat_n   = LAT_W'(TIMEOUT);
          pass_n  = 1'b0;
          done_n  = 1'b1;
          state_n = CHECK;
        end else begin
          cnt_n = wait_cnt + LAT_W'(1);
        end
      end

      CHECK: begin
        // pass/err during the done cycle reflect the capture; a result still
        // valid here shows up as LONG_VALID from the following cycle on.
        busy_n  = 1'b0;
        state_n = IDLE;
        if (dut_out_valid && (err_q == ERR_NONE)) begin
          err_n  = ERR_LONG;
          pass_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_q         <= ERR_NONE;
      latency       <= '0;
      cap_result    <= '0;
      wait_cnt      <= '0;
      exp_r         <= '0;
      fmode_r       <= '0;
      dut_in_valid  <= 1'b0;
      dut_in_number <= '0;
      dut_mode      <= '0;
    end else begin
      state         <= state_n;
      busy          <= busy_n;
      done          <= done_n;
      pass          <= pass_n;
      err_q         <= err_n;
      latency       <= lat_n;
      cap_result    <= cap_n;
      wait_cnt      <= cnt_n;
      exp_r         <= exp_n;
      fmode_r       <= fmode_n;
      dut_in_valid  <= vld_n;
      dut_in_number <= num_n;
      dut_mode      <= mode_n;
    end
  end

endmodule
